// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: one shared period counter (edge or center aligned) feeds
// CHANNELS compare outputs; duty/period/mode are double-buffered to period boundaries.
module pwm_multi_channel #(
  parameter int BIT_WIDTH = 8,
  parameter int CHANNELS  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          load,
  input  logic [CHANNELS*BIT_WIDTH-1:0] duty,
  input  logic [BIT_WIDTH-1:0]          max_value,
  input  logic                          center_mode,
  input  logic [CHANNELS-1:0]           invert,
  output logic [CHANNELS-1:0]           pwm_out,
  output logic [BIT_WIDTH-1:0]          counter,
  output logic                          period_end,
  output logic                          load_pending
);

  localparam logic [BIT_WIDTH-1:0] ONE = BIT_WIDTH'(1);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  dir_t                 dir_reg, dir_next;
  logic [BIT_WIDTH-1:0] counter_reg, counter_next;
  logic [BIT_WIDTH-1:0] max_sh_reg, max_act_reg;
  logic                 mode_sh_reg, mode_act_reg;
  logic                 pending_reg, pending_next;
  logic                 period_end_reg;
  logic                 boundary;
  logic                 boundary_en;
  logic                 transfer;
  logic                 center_ok;

  // Next-state for the shared counter and direction FSM
  always_comb begin
    counter_next = counter_reg;
    dir_next     = dir_reg;
    boundary     = 1'b0;
    center_ok    = mode_act_reg && (max_act_reg > ONE);

    if (!center_ok) begin
      dir_next = UP;
      if (counter_reg == max_act_reg) begin
        boundary     = 1'b1;
        counter_next = '0;
      end else begin
        counter_next = counter_reg + ONE;
      end
    end else begin
      case (dir_reg)
        UP: begin
          if (counter_reg < max_act_reg) begin
            counter_next = counter_reg + ONE;
          end else begin
            dir_next     = DOWN;
            counter_next = max_act_reg - ONE;
          end
        end
        DOWN: begin
          if (counter_reg > ONE) begin
            counter_next = counter_reg - ONE;
          end else begin
            boundary     = 1'b1;
            counter_next = '0;
            dir_next     = UP;
          end
        end
        default: begin
          counter_next = '0;
          dir_next     = UP;
        end
      endcase
    end

    boundary_en = enable && boundary;
    // A load landing on the boundary goes straight to active, never pending
    transfer    = boundary_en && (pending_reg || load);

    pending_next = pending_reg;
    if (boundary_en) begin
      pending_next = 1'b0;
    end else if (load) begin
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_reg    <= '0;
      dir_reg        <= UP;
      period_end_reg <= 1'b0;
      pending_reg    <= 1'b0;
      max_sh_reg     <= '1;
      max_act_reg    <= '1;
      mode_sh_reg    <= 1'b0;
      mode_act_reg   <= 1'b0;
    end else begin
      pending_reg    <= pending_next;
      period_end_reg <= boundary_en;
      if (enable) begin
        counter_reg <= counter_next;
        dir_reg     <= dir_next;
      end
      if (load) begin
        max_sh_reg  <= max_value;
        mode_sh_reg <= center_mode;
      end
      if (transfer) begin
        max_act_reg  <= load ? max_value   : max_sh_reg;
        mode_act_reg <= load ? center_mode : mode_sh_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [BIT_WIDTH-1:0] duty_sh_reg;
      logic [BIT_WIDTH-1:0] duty_act_reg;
      logic                 pwm_reg;

      // Compare uses the pre-update counter: one cycle from counter to pin
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          duty_sh_reg  <= '0;
          duty_act_reg <= '0;
          pwm_reg      <= 1'b0;
        end else begin
          if (load) begin
            duty_sh_reg <= duty[gi*BIT_WIDTH +: BIT_WIDTH];
          end
          if (transfer) begin
            duty_act_reg <= load ? duty[gi*BIT_WIDTH +: BIT_WIDTH] : duty_sh_reg;
          end
          if (enable) begin
            pwm_reg <= (counter_reg < duty_act_reg) ^ invert[gi];
          end
        end
      end

      assign pwm_out[gi] = pwm_reg;
    end
  endgenerate

  assign counter      = counter_reg;
  assign period_end   = period_end_reg;
  assign load_pending = pending_reg;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: edge/center periods, double buffering,
// enable freeze, invert, M=0 and asynchronous reset.
module tb_pwm_multi_channel;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [31:0] duty;
  logic [7:0]  max_value;
  logic        center_mode;
  logic [3:0]  invert;
  logic [3:0]  pwm_out;
  logic [7:0]  counter;
  logic        period_end;
  logic        load_pending;

  int checks = 0;
  int errors = 0;
  int cnt0, cnt1, cnt2, cnt3, cnt_pe;
  int exp_c [8];
  int exp_p0 [8];

  pwm_multi_channel #(.BIT_WIDTH(8), .CHANNELS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .load         (load),
    .duty         (duty),
    .max_value    (max_value),
    .center_mode  (center_mode),
    .invert       (invert),
    .pwm_out      (pwm_out),
    .counter      (counter),
    .period_end   (period_end),
    .load_pending (load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; duty = '0;
    max_value = '0; center_mode = 1'b0; invert = '0;
    exp_c  = '{1, 2, 3, 4, 3, 2, 1, 0};
    exp_p0 = '{1, 1, 0, 0, 0, 0, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_counter", counter, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_period_end", period_end, 0);
    check("rst_pending", load_pending, 0);
    #2 rst_n = 1'b1;

    // Load while disabled stays pending; reset period is 256 cycles
    load = 1'b1; max_value = 8'd9; center_mode = 1'b0;
    duty = {8'd5, 8'd0, 8'd255, 8'd3};
    tick();
    load = 1'b0;
    check("dis_load_pending", load_pending, 1);
    check("dis_counter_hold", counter, 0);
    enable = 1'b1;
    repeat (255) tick();
    check("m255_counter_top", counter, 255);
    check("m255_still_pending", load_pending, 1);
    tick();
    check("m255_wrap_counter", counter, 0);
    check("m255_period_end", period_end, 1);
    check("m255_pending_clear", load_pending, 0);

    // Edge mode, M=9
    cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0; cnt_pe = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("edge_counter_%0d", e), counter, e % 10);
      check($sformatf("edge_pwm0_%0d", e), pwm_out[0], ((e - 1) < 3) ? 1 : 0);
      cnt0 += pwm_out[0]; cnt1 += pwm_out[1]; cnt2 += pwm_out[2];
      cnt3 += pwm_out[3]; cnt_pe += period_end;
    end
    check("edge_ch0_high", cnt0, 3);
    check("edge_ch1_high", cnt1, 10);
    check("edge_ch2_high", cnt2, 0);
    check("edge_ch3_high", cnt3, 5);
    check("edge_period_ends", cnt_pe, 1);

    // Mid-period load at counter 5 waits for the wrap
    repeat (5) tick();
    check("mid_counter", counter, 5);
    load = 1'b1; duty = {8'd5, 8'd0, 8'd255, 8'd7};
    tick();
    load = 1'b0;
    check("mid_pending", load_pending, 1);
    check("mid_old_duty", pwm_out[0], 0);
    repeat (3) tick();
    check("mid_pending_hold", load_pending, 1);
    check("mid_counter_9", counter, 9);
    tick();
    check("mid_pending_clear", load_pending, 0);
    check("mid_wrap", counter, 0);
    cnt0 = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      cnt0 += pwm_out[0];
    end
    check("mid_ch0_high_new", cnt0, 7);

    // Invert is live
    invert = 4'b0010;
    tick();
    check("inv_ch1_first", pwm_out[1], 0);
    cnt1 = 0;
    for (int e = 2; e <= 10; e++) begin
      tick();
      cnt1 += pwm_out[1];
    end
    check("inv_ch1_high", cnt1, 0);
    invert = 4'b0000;

    // Enable freeze at counter 6
    repeat (6) tick();
    check("frz_counter", counter, 6);
    enable = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      check($sformatf("frz_counter_%0d", e), counter, 6);
      check($sformatf("frz_pwm_%0d", e), pwm_out, 4'b0011);
      check($sformatf("frz_pe_%0d", e), period_end, 0);
    end
    enable = 1'b1;
    tick();
    check("frz_resume", counter, 7);

    // Load coinciding with the boundary switches to center M=4 at once
    repeat (2) tick();
    check("lb_counter_9", counter, 9);
    load = 1'b1; max_value = 8'd4; center_mode = 1'b1;
    duty = {8'd255, 8'd0, 8'd0, 8'd2};
    tick();
    load = 1'b0;
    check("lb_pending", load_pending, 0);
    check("lb_counter", counter, 0);
    check("lb_period_end", period_end, 1);
    for (int e = 0; e < 8; e++) begin
      tick();
      check($sformatf("ctr_counter_%0d", e), counter, exp_c[e]);
      check($sformatf("ctr_pwm0_%0d", e), pwm_out[0], exp_p0[e]);
      check($sformatf("ctr_pwm3_%0d", e), pwm_out[3], 1);
      check($sformatf("ctr_pe_%0d", e), period_end, (e == 7) ? 1 : 0);
    end

    // M=0, duty0=0: boundary every cycle, ch0 constant low
    load = 1'b1; max_value = 8'd0; center_mode = 1'b0;
    duty = {8'd0, 8'd0, 8'd1, 8'd0};
    tick();
    load = 1'b0;
    check("m0_pending", load_pending, 1);
    repeat (7) tick();
    check("m0_transfer_counter", counter, 0);
    check("m0_transfer_pending", load_pending, 0);
    for (int e = 0; e < 4; e++) begin
      tick();
      check($sformatf("m0_counter_%0d", e), counter, 0);
      check($sformatf("m0_pe_%0d", e), period_end, 1);
      check($sformatf("m0_pwm_%0d", e), pwm_out, 4'b0010);
    end

    // Asynchronous reset mid-cycle discards shadows
    load = 1'b1; max_value = 8'd9; duty = {8'd0, 8'd0, 8'd0, 8'd9};
    tick();
    load = 1'b0;
    repeat (3) tick();
    check("pre_rst_counter", counter, 3);
    check("pre_rst_pwm0", pwm_out[0], 1);
    load = 1'b1; duty = {8'd0, 8'd0, 8'd0, 8'd1};
    tick();
    load = 1'b0;
    check("pre_rst_pending", load_pending, 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_counter", counter, 0);
    check("arst_pwm", pwm_out, 0);
    check("arst_pending", load_pending, 0);
    check("arst_period_end", period_end, 0);
    #1 rst_n = 1'b1;
    repeat (255) tick();
    check("arst_m255_top", counter, 255);
    check("arst_m255_pe_low", period_end, 0);
    tick();
    check("arst_m255_wrap", counter, 0);
    check("arst_m255_pe", period_end, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
